// File: rtl/bcd_serial_subtractor_if.sv
// Handshake and data bundle between a requester and the serial BCD subtractor.
// Latency: none, wires only.
// Backpressure: none; start is honoured only while the slave reports busy=0.
//
// Signals: start/A/B are driven by the master; busy/done/Diff/Neg/Invalid by the slave.
// A, B and Diff are packed BCD with digit 0 in bits [3:0].
interface bcd_serial_subtractor_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   A;
    logic [4*DIGITS-1:0]   B;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   Diff;
    logic                  Neg;
    logic                  Invalid;

    modport master (
        output start, A, B,
        input  busy, done, Diff, Neg, Invalid
    );

    modport slave (
        input  start, A, B,
        output busy, done, Diff, Neg, Invalid
    );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Serial packed-BCD subtractor: |A-B| one digit per clock, LSD first, with sign and invalid flags.
// Latency: done after 1 cycle (invalid digit), DIGITS+1 cycles (A>=B) or 2*DIGITS+1 cycles (A<B).
// Backpressure: start is ignored while busy; results are held until the next operation completes.
//
// Ports: clk, rst (synchronous, active high), bus (slave modport: start/A/B in,
//        busy/done/Diff/Neg/Invalid out, all outputs registered).
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    bcd_serial_subtractor_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SUB    = 2'd1,
        NEGATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         state;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [W-1:0]   r_r;
    logic [IW-1:0]  idx;
    logic           borrow;

    logic [W-1:0]   diff_q;
    logic           neg_q;
    logic           inv_q;
    logic           busy_q;
    logic           done_q;

    assign bus.Diff    = diff_q;
    assign bus.Neg     = neg_q;
    assign bus.Invalid = inv_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    // One digit step shared by both passes. In NEGATE the minuend is 0 and the
    // subtrahend is the partial result, which turns a ten's-complement raw
    // difference back into a magnitude.
    logic [3:0]     op_x;
    logic [3:0]     op_y;
    logic [4:0]     t;
    logic [3:0]     r_dig;
    logic [W-1:0]   r_next;
    logic           last;
    logic           in_bad;

    always_comb begin
        op_x = '0;
        op_y = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                op_x = (state == NEGATE) ? 4'd0 : a_r[4*i +: 4];
                op_y = (state == NEGATE) ? r_r[4*i +: 4] : b_r[4*i +: 4];
            end
        end
        // Range is -10..9, so bit 4 is the sign in 5-bit two's complement.
        t     = {1'b0, op_x} - {1'b0, op_y} - {4'b0000, borrow};
        // Adding 10 modulo 16 to the low nibble yields the corrected digit.
        r_dig = t[4] ? (t[3:0] + 4'd10) : t[3:0];
        r_next = r_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                r_next[4*i +: 4] = r_dig;
            end
        end
    end

    assign last = (idx == IW'(DIGITS - 1));

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((bus.A[4*i +: 4] > 4'd9) || (bus.B[4*i +: 4] > 4'd9)) begin
                in_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            r_r    <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            diff_q <= '0;
            neg_q  <= 1'b0;
            inv_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r    <= bus.A;
                        b_r    <= bus.B;
                        r_r    <= '0;
                        idx    <= '0;
                        borrow <= 1'b0;
                        busy_q <= 1'b1;
                        if (in_bad) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            diff_q <= '0;
                            neg_q  <= 1'b0;
                            inv_q  <= 1'b1;
                        end else begin
                            state <= SUB;
                        end
                    end
                end
                SUB: begin
                    r_r    <= r_next;
                    borrow <= t[4];
                    idx    <= idx + 1'b1;
                    if (last) begin
                        idx <= '0;
                        if (t[4]) begin
                            // Borrow out of the top digit: A < B, so run the
                            // correction pass instead of exposing the borrow.
                            state  <= NEGATE;
                            borrow <= 1'b0;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            diff_q <= r_next;
                            neg_q  <= 1'b0;
                            inv_q  <= 1'b0;
                        end
                    end
                end
                NEGATE: begin
                    r_r    <= r_next;
                    borrow <= t[4];
                    idx    <= idx + 1'b1;
                    if (last) begin
                        idx    <= '0;
                        state  <= DONE;
                        done_q <= 1'b1;
                        diff_q <= r_next;
                        neg_q  <= 1'b1;
                        inv_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
